// File: rtl/alu_arbiter_if.sv
// Requester-side and ALU-side signals of alu_arbiter, bundled as one interface.
// slave: the arbiter's view; master: the requesters plus the ALU driving it.
interface alu_arbiter_if;
    logic        req0;
    logic        req1;
    logic [31:0] opA0;
    logic [31:0] opA1;
    logic [31:0] opB0;
    logic [31:0] opB1;
    logic [3:0]  aluop0;
    logic [3:0]  aluop1;
    logic        done0;
    logic        done1;
    logic [31:0] result;
    logic [2:0]  flags;
    logic        busy;
    logic        grant;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  aluOp;
    logic [31:0] aluOut;
    logic        aluNeg;
    logic        aluZero;
    logic        aluOf;

    modport slave (
        input  req0, req1, opA0, opA1, opB0, opB1, aluop0, aluop1,
        output done0, done1, result, flags, busy, grant,
        output aluA, aluB, aluOp,
        input  aluOut, aluNeg, aluZero, aluOf
    );

    modport master (
        output req0, req1, opA0, opA1, opB0, opB1, aluop0, aluop1,
        input  done0, done1, result, flags, busy, grant,
        input  aluA, aluB, aluOp,
        output aluOut, aluNeg, aluZero, aluOf
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU: IDLE -> EXEC -> DONE.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter (
    input  logic          CLK,
    input  logic          RST,
    alu_arbiter_if.slave  bus
);
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t      stateReg, stateNext;
    logic        grantReg, grantNext;
    word_t       opAReg, opANext;
    word_t       opBReg, opBNext;
    logic [3:0]  opReg, opNext;
    word_t       resultReg, resultNext;
    logic [2:0]  flagsReg, flagsNext;

    logic [1:0]  reqVec;
    logic [1:0]  doneVec;
    word_t       opAIn [2];
    word_t       opBIn [2];
    logic [3:0]  opIn [2];
    logic        winner;

    assign reqVec   = {bus.req1, bus.req0};
    assign opAIn[0] = bus.opA0;
    assign opAIn[1] = bus.opA1;
    assign opBIn[0] = bus.opB0;
    assign opBIn[1] = bus.opB1;
    assign opIn[0]  = bus.aluop0;
    assign opIn[1]  = bus.aluop1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg  <= IDLE;
            grantReg  <= 1'b1;
            opAReg    <= '0;
            opBReg    <= '0;
            opReg     <= '0;
            resultReg <= '0;
            flagsReg  <= '0;
        end else begin
            stateReg  <= stateNext;
            grantReg  <= grantNext;
            opAReg    <= opANext;
            opBReg    <= opBNext;
            opReg     <= opNext;
            resultReg <= resultNext;
            flagsReg  <= flagsNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        grantNext  = grantReg;
        opANext    = opAReg;
        opBNext    = opBReg;
        opNext     = opReg;
        resultNext = resultReg;
        flagsNext  = flagsReg;
        winner     = 1'b0;
        case (stateReg)
            IDLE: begin
                if (|reqVec) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    winner = reqVec[0] ? 1'b0 : 1'b1;
`else
                    // On a tie the requester that was not served last wins.
                    winner = (&reqVec) ? ~grantReg : reqVec[1];
`endif
                    grantNext = winner;
                    opANext   = opAIn[winner];
                    opBNext   = opBIn[winner];
                    opNext    = opIn[winner];
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                resultNext = bus.aluOut;
                flagsNext  = {bus.aluNeg, bus.aluZero, bus.aluOf};
                stateNext  = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_done
        assign doneVec[gi] = (stateReg == DONE) && (grantReg == 1'(gi));
    end

    // ALU inputs come straight from the operand registers so they stay quiet while idle.
    assign bus.done0  = doneVec[0];
    assign bus.done1  = doneVec[1];
    assign bus.result = resultReg;
    assign bus.flags  = flagsReg;
    assign bus.busy   = (stateReg != IDLE);
    assign bus.grant  = grantReg;
    assign bus.aluA   = opAReg;
    assign bus.aluB   = opBReg;
    assign bus.aluOp  = opReg;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: plays both requesters and a small ALU model.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;

    typedef struct {
        int          who;
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    alu_arbiter_if bus();

    alu_arbiter dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] aluOutM;
    logic        aluOfM;
    always_comb begin
        aluOutM = 32'h0;
        aluOfM  = 1'b0;
        case (bus.aluOp)
            OP_ADD: begin
                aluOutM = bus.aluA + bus.aluB;
                aluOfM  = (bus.aluA[31] == bus.aluB[31]) && (aluOutM[31] != bus.aluA[31]);
            end
            OP_SUB: begin
                aluOutM = bus.aluA - bus.aluB;
                aluOfM  = (bus.aluA[31] != bus.aluB[31]) && (aluOutM[31] != bus.aluA[31]);
            end
            OP_AND:  aluOutM = bus.aluA & bus.aluB;
            default: aluOutM = bus.aluA ^ bus.aluB;
        endcase
    end
    assign bus.aluOut  = aluOutM;
    assign bus.aluNeg  = aluOutM[31];
    assign bus.aluZero = (aluOutM == 32'h0);
    assign bus.aluOf   = aluOfM;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) bus.req0 = v;
        else          bus.req1 = v;
    endtask

    task automatic set_ops(input int who, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op);
        if (who == 0) begin
            bus.opA0 = a; bus.opB0 = b; bus.aluop0 = op;
        end else begin
            bus.opA1 = a; bus.opB1 = b; bus.aluop1 = op;
        end
    endtask

    task automatic push_exp(input int who, input logic [31:0] res, input logic [2:0] flg);
        exp_t e;
        e.who = who;
        e.res = res;
        e.flg = flg;
        sb.push_back(e);
    endtask

    // Issue one request, wait (bounded) for a done, then return to an IDLE cycle.
    task automatic run_op(input int who, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] op, input logic [31:0] expRes,
                          input logic [2:0] expFlg, output int lat, output int seen);
        push_exp(who, expRes, expFlg);
        set_ops(who, a, b, op);
        set_req(who, 1'b1);
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (bus.done0 || bus.done1) begin
                seen = {30'd0, bus.done1, bus.done0};
                break;
            end
        end
        set_req(who, 1'b0);
        if (seen != 0) step();
    endtask

    task automatic pop_compare(input string tag, input int seen);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_sb_empty: done pattern %0d with no expected entry", tag, seen);
        end else begin
            e = sb.pop_front();
            if (seen !== (e.who == 0 ? 1 : 2)) begin
                failures++;
                $display("FAIL %s_who: done pattern %0d, required %0d", tag, seen, (e.who == 0 ? 1 : 2));
            end
            checks++;
            if (bus.result !== e.res) begin
                failures++;
                $display("FAIL %s_result: got %h, required %h", tag, bus.result, e.res);
            end
            checks++;
            if (bus.flags !== e.flg) begin
                failures++;
                $display("FAIL %s_flags: got %b, required %b", tag, bus.flags, e.flg);
            end
            $display("txn %s: req%0d result=%h flags=%b", tag, e.who, bus.result, bus.flags);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        set_ops(0, 32'h1234_5678, 32'h9abc_def0, OP_SUB);
        set_ops(1, 32'h0f0f_0f0f, 32'h1111_1111, OP_XOR);
        repeat (3) step();
        checks++;
        if ({bus.done0, bus.done1, bus.busy, bus.grant} !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ctrl: {done0,done1,busy,grant}=%b, required 0001",
                     {bus.done0, bus.done1, bus.busy, bus.grant});
        end
        checks++;
        if (bus.result !== 32'h0 || bus.flags !== 3'b000) begin
            failures++;
            $display("FAIL reset_result: result=%h flags=%b, required 0/000", bus.result, bus.flags);
        end
        checks++;
        if (bus.aluA !== 32'h0 || bus.aluB !== 32'h0 || bus.aluOp !== 4'h0) begin
            failures++;
            $display("FAIL reset_alu: aluA=%h aluB=%h aluOp=%h, required zeros", bus.aluA, bus.aluB, bus.aluOp);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b, required 0", bus.busy);
        end
        $display("txn reset: released");
    endtask

    task automatic test_single();
        int lat, seen;
        run_op(0, 32'd5, 32'd7, OP_ADD, 32'd12, 3'b000, lat, seen);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL single_latency: %0d cycles, required 2", lat);
        end
        pop_compare("single", seen);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_busy_after: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_flags();
        int lat, seen;
        run_op(1, 32'd3, 32'd3, OP_SUB, 32'd0, 3'b010, lat, seen);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL flags_latency: %0d cycles, required 2", lat);
        end
        pop_compare("flags_zero", seen);
        run_op(1, 32'd10, 32'd3, OP_SUB, 32'd7, 3'b000, lat, seen);
        pop_compare("flags_sub_order", seen);
        run_op(1, 32'h7fff_ffff, 32'd1, OP_ADD, 32'h8000_0000, 3'b101, lat, seen);
        pop_compare("flags_overflow", seen);
    endtask

    task automatic test_contention();
        logic [1:0] expDone;
        set_ops(0, 32'd100, 32'd58, OP_SUB);
        set_ops(1, 32'hffff_ffff, 32'd1, OP_ADD);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            push_exp(0, 32'd42, 3'b000);
`else
            if (k % 2 == 0) push_exp(0, 32'd42, 3'b000);
            else            push_exp(1, 32'd0, 3'b010);
`endif
        end
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            expDone = 2'b00;
            if (i % 3 == 2) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                expDone = 2'b01;
`else
                expDone = ((i / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            end
            checks++;
            if ({bus.done1, bus.done0} !== expDone) begin
                failures++;
                $display("FAIL contention_done_c%0d: {done1,done0}=%b, required %b",
                         i, {bus.done1, bus.done0}, expDone);
            end
            if (expDone != 2'b00) pop_compare("contention", {30'd0, bus.done1, bus.done0});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        step();
    endtask

    task automatic test_late();
        logic [1:0] expDone;
        set_ops(0, 32'd20, 32'd22, OP_AND);
        set_ops(1, 32'h8000_0000, 32'd1, OP_SUB);
        push_exp(0, 32'd20, 3'b000);
        push_exp(1, 32'h7fff_ffff, 3'b001);
        bus.req0 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 1) bus.req1 = 1'b1;
            expDone = (i == 2) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00;
            checks++;
            if ({bus.done1, bus.done0} !== expDone) begin
                failures++;
                $display("FAIL late_done_c%0d: {done1,done0}=%b, required %b",
                         i, {bus.done1, bus.done0}, expDone);
            end
            if (i == 4) begin
                checks++;
                if (bus.grant !== 1'b1 || bus.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL late_grant: grant=%b busy=%b, required 1/1", bus.grant, bus.busy);
                end
            end
            if (bus.done0) bus.req0 = 1'b0;
            if (bus.done1) bus.req1 = 1'b0;
            if (expDone != 2'b00) pop_compare("late", {30'd0, bus.done1, bus.done0});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic test_reset_midop();
        int lat, seen;
        set_ops(0, 32'd1, 32'd2, OP_ADD);
        bus.req0 = 1'b1;
        step();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_exec: busy=%b, required 1", bus.busy);
        end
        rst = 1'b1;
        bus.req0 = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.done0, bus.done1, bus.busy, bus.grant} !== 4'b0001) begin
            failures++;
            $display("FAIL midop_ctrl: {done0,done1,busy,grant}=%b, required 0001",
                     {bus.done0, bus.done1, bus.busy, bus.grant});
        end
        checks++;
        if (bus.result !== 32'h0 || bus.flags !== 3'b000) begin
            failures++;
            $display("FAIL midop_result: result=%h flags=%b, required 0/000", bus.result, bus.flags);
        end
        step();
        checks++;
        if ({bus.done0, bus.done1, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL midop_nodone: {done0,done1,busy}=%b, required 000",
                     {bus.done0, bus.done1, bus.busy});
        end
        $display("txn midop: operation discarded by reset");
        run_op(0, 32'ha5a5_0000, 32'h0000_5a5a, OP_XOR, 32'ha5a5_5a5a, 3'b100, lat, seen);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL midop_fresh_latency: %0d cycles, required 2", lat);
        end
        pop_compare("midop_fresh", seen);
    endtask

    task automatic test_hold();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.busy !== 1'b0 || bus.done0 !== 1'b0 || bus.done1 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_idle: %0d cycles with busy/done high, required 0", bad);
        end
        checks++;
        if (bus.aluA !== 32'ha5a5_0000 || bus.aluB !== 32'h0000_5a5a || bus.aluOp !== OP_XOR) begin
            failures++;
            $display("FAIL hold_alu: aluA=%h aluB=%h aluOp=%h, required a5a50000/00005a5a/%h",
                     bus.aluA, bus.aluB, bus.aluOp, OP_XOR);
        end
        checks++;
        if (bus.result !== 32'ha5a5_5a5a || bus.flags !== 3'b100) begin
            failures++;
            $display("FAIL hold_result: result=%h flags=%b, required a5a55a5a/100", bus.result, bus.flags);
        end
        $display("txn hold: 10 idle cycles");
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        set_ops(0, 32'h0, 32'h0, OP_ADD);
        set_ops(1, 32'h0, 32'h0, OP_ADD);
        test_reset();
        test_single();
        test_flags();
        test_contention();
        test_late();
        test_reset_midop();
        test_hold();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single combinational ALU (32-bit `portA`/`portB`/`portOut`, 4-bit `ALUOP`, neg/zero/overflow flags) between two requesters, e.g. two cores or a core and a debug/test port. Each requester uses a level req / pulse done handshake. The arbiter grants one requester at a time, latches that requester's operands, drives the ALU for one cycle, registers the result and flags, and returns them with a one-cycle done pulse. It sits between the requesters and the ALU's input side.

## Interface
Parameters:
- none; operand and result width fixed at 32 bits (`word_t`); op width fixed at 4 bits.

Ports:
- `CLK`  in  1  system clock; every register updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  requester wants an operation; held high until its done.
- `opA0`, `opA1`  in  32  operand A per requester.
- `opB0`, `opB1`  in  32  operand B per requester.
- `aluop0`, `aluop1`  in  4  ALU opcode per requester.
- `done0`, `done1`  out  1  one-cycle pulse; result/flags valid for that requester.
- `result`  out  32  registered ALU result (shared by both requesters).
- `flags`  out  3  registered {neg, zero, of}.
- `busy`  out  1  high in EXEC and DONE states.
- `grant`  out  1  index of the requester currently or last granted.
- `aluA`, `aluB`  out  32  operands driven to the ALU.
- `aluOp`  out  4  opcode driven to the ALU.
- `aluOut`  in  32  ALU result.
- `aluNeg`, `aluZero`, `aluOf`  in  1  ALU flags.

## Operation
- FSM has three states: IDLE → EXEC → DONE → IDLE.
- IDLE:
  - If any req is high, pick a winner, latch its opA/opB/aluop into the operand registers, set `grant` to the winner and go to EXEC.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only req0 high: requester 0 wins. Only req1 high: requester 1 wins.
  - Both high: round-robin; the winner is the requester not equal to `grant`.
- EXEC:
  - `aluA`/`aluB`/`aluOp` come from the operand registers.
  - At the end of the cycle, capture `aluOut` into `result` and {aluNeg, aluZero, aluOf} into `flags`. Go to DONE.
- DONE:
  - `done[grant]` is 1 and the other done is 0. Go to IDLE.
- Requester contract:
  - Deassert req at the edge that ends its done cycle.
  - A req still high in the following IDLE cycle is a new request.
- Requests arriving in EXEC or DONE are not sampled; they wait for IDLE.
- `aluA`/`aluB`/`aluOp` always reflect the operand registers. In IDLE they hold the last operation's values, so there is no ALU input toggling while idle.
- `result`/`flags` hold their value until the next EXEC capture.
- Arithmetic: the arbiter performs none; it passes 32-bit values unmodified.

## Timing
- Reset values (held while RST=1 and for the first cycle after): state=IDLE; done0=done1=0; busy=0; grant=1 (so requester 0 wins the first tie); result=0; flags=0; aluA=aluB=0; aluOp=0.
- Latency: req sampled high in IDLE cycle T → EXEC in T+1 → done pulse and valid result in T+2 → IDLE in T+3.
- Throughput: one operation per 3 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1…
- Reset mid-operation (RST in EXEC or DONE): the operation is discarded, no done is issued, and all registers return to reset values at that edge.
- Simultaneous RST and req: reset wins; the request is seen in the first non-reset IDLE cycle.
- A req dropped before its done (contract violation): the operation still completes and done still pulses.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority; requester 0 always wins when both req are high, and `grant` history is ignored.
  - Undefined (default): round-robin as above.
- Latency, handshake and reset behaviour are identical in both builds.

## Test plan
- Reset, then single request: req0=1, opA0=5, opB0=7, aluop0=ADD → done0 at T+2, result=12, flags=000, done1 never high.
- Flags: req1=1, opA1=3, opB1=3, aluop1=SUB → done1 at T+2, result=0, flags zero bit=1. Then 0x7FFFFFFF+1 ADD → result=0x80000000, neg=1, of=1.
- Contention (default build): req0 and req1 held high for 12 cycles → done pulses alternate 0,1,0,1, one every 3 cycles, first done is done0. Under `ALU_ARB_FIXED_PRIO_EN` → all dones are done0.
- Late arrival: req1 rises in the EXEC cycle of requester 0's op → not granted until the IDLE cycle after done0; done1 arrives 3 cycles later.
- Reset mid-op: RST=1 during EXEC → no done pulse; result=0, busy=0, grant=1 next cycle; a fresh req0 then completes normally.
- Hold: after done, with no req for 10 cycles → result/flags/aluA/aluB/aluOp unchanged, busy=0.
